// File: rtl/mmio_uart_ctrl_pkg.sv
// rtl/mmio_uart_ctrl_pkg.sv - register map and STATUS layout for mmio_uart_ctrl
//
// Package mmio_pkg: byte offsets of the 0x8000_00xx window and bit/field
// positions inside the STATUS register. Imported by the controller top.

package mmio_pkg;

    // Register offsets within the window (word aligned; addr[1:0] ignored)
    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RX_DATA = 8'h04;
    localparam logic [7:0] OFF_TX_DATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h10;
    localparam logic [7:0] OFF_INSTR   = 8'h14;
    localparam logic [7:0] OFF_CNT_RST = 8'h18;

    // STATUS bit positions
    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_OVF       = 2;
    localparam int ST_RX_UNF       = 3;

    // STATUS occupancy fields (8 bits each, zero-extended FIFO counts)
    localparam int ST_RX_CNT_LSB   = 8;
    localparam int ST_TX_CNT_LSB   = 16;
    localparam int ST_CNT_W        = 8;

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// rtl/mmio_uart_ctrl_if.sv - CPU load/store bus between datapath and the MMIO block
//
// Signals:
//   req_valid  access this cycle (already decoded to this block)
//   req_we     1 = store, 0 = load
//   req_addr   byte offset in window
//   req_wdata  store data
//   req_wbe    store byte enables
//   rsp_rdata  load data, valid the cycle after a load
// Modports: master (CPU side), slave (MMIO block side).

interface mmio_uart_ctrl_if #(
    parameter int DWIDTH = 32
) ();
    logic              req_valid;
    logic              req_we;
    logic [7:0]        req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [3:0]        req_wbe;
    logic [DWIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wbe,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wbe,
        output rsp_rdata
    );
endinterface

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// rtl/mmio_uart_ctrl_sync_fifo.sv - single-clock byte FIFO with explicit occupancy counter
//
// Module sync_fifo (WIDTH, DEPTH; DEPTH a power of two, >= 2).
// Ports:
//   clk, rst    clock, asynchronous active-high reset (empties the FIFO)
//   push, din   write request and data; ignored while full
//   pop         read request; ignored while empty
//   dout        head entry, combinational; 0 while empty
//   full, empty status flags derived from count
//   count       occupancy, clog2(DEPTH)+1 bits

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    // Full/empty are judged on the pre-edge state, so a push while full is
    // dropped even when a pop frees a slot in the same cycle.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Masking the head keeps dout at 0 after reset, when the storage array
    // still holds stale bytes.
    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    // Storage has no reset: the pointers and counter alone define contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MMIO UART controller: RX/TX FIFOs, STATUS, cycle/instret counters
//
// Optional feature macro: MMIO_UART_ERR_FLAGS_EN (sticky TX overflow / RX
// underflow flags in STATUS bits 2/3, cleared by write-1 with wbe[0]).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus             mmio_uart_ctrl_if.slave load/store bus; one-cycle read latency
//   inst_retired    pulse per retired instruction
//   rx_data/rx_valid/rx_ready  from/to uart_receiver
//   tx_data/tx_valid/tx_ready  to/from uart_transmitter

module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8,
    parameter int DWIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_ctrl_if.slave      bus,
    input  logic                 inst_retired,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    // Decoded bus request
    logic              w_load;
    logic              w_store;
    logic [7:0]        w_off;

    // RX FIFO
    logic [7:0]        w_rx_head;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [RX_CW-1:0]  w_rx_count;
    logic              w_rx_rd;
    logic              w_rx_pop;
    logic              w_rx_underflow;

    // TX FIFO
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [TX_CW-1:0]  w_tx_count;
    logic              w_tx_wr;
    logic              w_tx_drop;

    // Counters and read path
    logic              w_cnt_clr;
    logic [DWIDTH-1:0] r_cycle;
    logic [DWIDTH-1:0] r_instr;
    logic [DWIDTH-1:0] r_rsp_rdata;
    logic [31:0]       w_status;
    logic [DWIDTH-1:0] w_rdata;
    logic              w_tx_ovf;
    logic              w_rx_unf;

    assign w_load  = bus.req_valid & ~bus.req_we;
    assign w_store = bus.req_valid &  bus.req_we;
    assign w_off   = {bus.req_addr[7:2], 2'b00};

    // A load of RX_DATA pops only when there is something to pop; reading
    // an empty FIFO returns the masked head (0).
    assign w_rx_rd        = w_load && (w_off == OFF_RX_DATA);
    assign w_rx_pop       = w_rx_rd & ~w_rx_empty;
    assign w_rx_underflow = w_rx_rd &  w_rx_empty;

    assign w_tx_wr   = w_store && (w_off == OFF_TX_DATA) && bus.req_wbe[0];
    assign w_tx_drop = w_tx_wr & w_tx_full;

    assign w_cnt_clr = w_store && (w_off == OFF_CNT_RST) && (bus.req_wbe != 4'b0000);

    // rx_ready depends only on the pre-edge full flag; a same-cycle pop does
    // not open the door, so the receiver retries on the following cycle.
    assign rx_ready = ~w_rx_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid & rx_ready),
        .din   (rx_data),
        .pop   (w_rx_pop),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_wr),
        .din   (bus.req_wdata[7:0]),
        .pop   (tx_valid & tx_ready),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    assign tx_valid = ~w_tx_empty;

`ifdef MMIO_UART_ERR_FLAGS_EN
    logic r_tx_ovf;
    logic r_rx_unf;
    logic w_status_wr;

    assign w_status_wr = w_store && (w_off == OFF_STATUS) && bus.req_wbe[0];

    // Set has priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
        end else begin
            if (w_tx_drop) begin
                r_tx_ovf <= 1'b1;
            end else if (w_status_wr && bus.req_wdata[ST_TX_OVF]) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_rx_underflow) begin
                r_rx_unf <= 1'b1;
            end else if (w_status_wr && bus.req_wdata[ST_RX_UNF]) begin
                r_rx_unf <= 1'b0;
            end
        end
    end

    assign w_tx_ovf = r_tx_ovf;
    assign w_rx_unf = r_rx_unf;
`else
    assign w_tx_ovf = 1'b0;
    assign w_rx_unf = 1'b0;
`endif

    always_comb begin
        w_status                                 = '0;
        w_status[ST_TX_NOT_FULL]                 = ~w_tx_full;
        w_status[ST_RX_NOT_EMPTY]                = ~w_rx_empty;
        w_status[ST_TX_OVF]                      = w_tx_ovf;
        w_status[ST_RX_UNF]                      = w_rx_unf;
        w_status[ST_RX_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(w_rx_count);
        w_status[ST_TX_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(w_tx_count);
    end

    // Read mux sees pre-edge state; the registered copy below gives the
    // same one-cycle latency as the memories.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_STATUS:  w_rdata = DWIDTH'(w_status);
            OFF_RX_DATA: w_rdata = DWIDTH'(w_rx_head);
            OFF_CYCLE:   w_rdata = r_cycle;
            OFF_INSTR:   w_rdata = r_instr;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= '0;
        end else if (w_load) begin
            r_rsp_rdata <= w_rdata;
        end
    end

    assign bus.rsp_rdata = r_rsp_rdata;

    // Counter clear overrides the increment of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else if (w_cnt_clr) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else begin
            r_cycle <= r_cycle + DWIDTH'(1);
            if (inst_retired) begin
                r_instr <= r_instr + DWIDTH'(1);
            end
        end
    end

    // Bus bits that carry no information for this block.
    logic w_unused;
    assign w_unused = ^{bus.req_addr[1:0], bus.req_wdata[DWIDTH-1:8],
                        w_tx_drop, w_rx_underflow};

endmodule
